sseg_scan_ctrl: RTL

Time-multiplexed scan controller for a 4-digit common-enable seven-segment display. Holds a 16-bit hex value and 4 decimal points, cycles one digit at a time through a single `hex_to_sseg` decoder instance, and drives registered, glitch-free active-high digit enables and segments. New values are double-buffered and committed only at frame boundaries, so a display frame never mixes old and new digits.

---
 rtl/sseg_scan_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a double-buffered display value.
// Define SSEG_LZ_BLANK_EN to enable leading-zero blanking.

module hex_to_sseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = '0;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = '0;
    endcase
  end
endmodule

module sseg_scan_ctrl #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] hex_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [7:0]  sseg,
  output logic        frame_tick,
  output logic        pending
);
  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] hex;
  } frame_t;

  logic [DIV_WIDTH-1:0] pre;
  logic [1:0]           idx, idx_next;
  frame_t               shadow, shadow_next, disp, disp_next;
  logic                 pending_next;
  logic                 digit_end, frame_end;
  logic [3:0]           nib;
  logic                 dp_bit;
  logic [6:0]           seg_dec;
  logic [7:0]           sseg_next;

  always_comb begin
    digit_end    = (pre == '1);
    frame_end    = digit_end && (idx == 2'd3);
    idx_next     = digit_end ? idx + 2'd1 : idx;
    shadow_next  = shadow;
    disp_next    = disp;
    pending_next = pending;
    if (load) begin
      shadow_next = frame_t'({dp_in, hex_in});
      if (frame_end) begin
        // Load on the boundary bypasses the shadow so it is visible next frame.
        disp_next    = frame_t'({dp_in, hex_in});
        pending_next = 1'b0;
      end else begin
        pending_next = 1'b1;
      end
    end else if (frame_end && pending) begin
      disp_next    = shadow;
      pending_next = 1'b0;
    end
  end

  always_comb begin
    nib    = disp_next.hex[idx_next*4 +: 4];
    dp_bit = disp_next.dp[idx_next];
  end

  hex_to_sseg u_dec (
    .hex (nib),
    .seg (seg_dec)
  );

`ifdef SSEG_LZ_BLANK_EN
  logic blank3, blank2, blank1;
  logic [3:0] blank;

  // A digit blanks only if it is a bare zero and every digit above it is blanked.
  always_comb begin
    blank3 = (disp_next.hex[15:12] == 4'h0) && !disp_next.dp[3];
    blank2 = blank3 && (disp_next.hex[11:8] == 4'h0) && !disp_next.dp[2];
    blank1 = blank2 && (disp_next.hex[7:4] == 4'h0) && !disp_next.dp[1];
    blank  = {blank3, blank2, blank1, 1'b0};
    sseg_next = blank[idx_next] ? 8'h00 : {dp_bit, seg_dec};
  end
`else
  always_comb begin
    sseg_next = {dp_bit, seg_dec};
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      an         <= '0;
      sseg       <= '0;
      frame_tick <= 1'b0;
    end else begin
      pre        <= pre + DIV_WIDTH'(1);
      idx        <= idx_next;
      shadow     <= shadow_next;
      disp       <= disp_next;
      pending    <= pending_next;
      an         <= 4'b0001 << idx_next;
      sseg       <= sseg_next;
      frame_tick <= frame_end;
    end
  end
endmodule
